// File: rtl/acc_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_control_unit_if
//  Description : Bundle between the accumulator control unit, its
//                instruction ROM and the downstream 8-bit ALU. Signal
//                directions are named from the control unit's side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_control_unit_if #(
  parameter int ADDR_W = 8
);
  logic              i_hold;
  logic [ADDR_W-1:0] o_instr_addr;
  logic [15:0]       i_instruction;
  logic [2:0]        o_alu_control;
  logic              o_reg_output_alu;
  logic [7:0]        o_operand_a;
  logic [7:0]        o_operand_b;
  logic [7:0]        i_alu_result;
  logic              i_n_a;
  logic              i_z_a;
  logic              i_c_a;
  logic              i_n_b;
  logic              i_z_b;
  logic              i_c_b;
  logic [7:0]        o_acc_a;
  logic [7:0]        o_acc_b;
  logic              o_halted;

  // Control unit side
  modport master (
    input  i_hold, i_instruction, i_alu_result,
    input  i_n_a, i_z_a, i_c_a, i_n_b, i_z_b, i_c_b,
    output o_instr_addr, o_alu_control, o_reg_output_alu,
    output o_operand_a, o_operand_b, o_acc_a, o_acc_b, o_halted
  );

  // ROM / ALU / environment side
  modport slave (
    output i_hold, i_instruction, i_alu_result,
    output i_n_a, i_z_a, i_c_a, i_n_b, i_z_b, i_c_b,
    input  o_instr_addr, o_alu_control, o_reg_output_alu,
    input  o_operand_a, o_operand_b, o_acc_a, o_acc_b, o_halted
  );
endinterface
`default_nettype wire

// File: rtl/acc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acc_control_unit
//  Description : Three-cycle fetch/decode/execute sequencer for the 8-bit
//                ALU. Owns the PC and accumulators A/B, drives ALU opcode,
//                operands and flag-bank select, writes results back and
//                branches on the ALU's registered flags.
//                Optional macro ACC_CALL_STACK_EN adds CALL/RET with a
//                STACK_D deep return stack; otherwise those classes are NOPs.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_control_unit #(
  parameter int ADDR_W  = 8,
  parameter int STACK_D = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  acc_control_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [2:0] c_CLS_ALU    = 3'b000;
  localparam logic [2:0] c_CLS_LOADI  = 3'b001;
  localparam logic [2:0] c_CLS_JMP    = 3'b010;
  localparam logic [2:0] c_CLS_BRANCH = 3'b011;
  localparam logic [2:0] c_CLS_CALL   = 3'b100;
  localparam logic [2:0] c_CLS_RET    = 3'b101;
  localparam logic [2:0] c_CLS_HALT   = 3'b111;
  localparam logic [2:0] c_ALU_IDLE   = 3'd7;

  state_t            r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc_inc, w_imm_addr;
  logic [15:0]       r_ir, w_ir_next;
  logic [7:0]        r_acc_a, r_acc_b, w_acc_a_next, w_acc_b_next;
  logic [2:0]        w_alu_control;
  logic              w_bank;
  logic [7:0]        w_op_a, w_op_b;
  logic              w_taken;

  // Instruction fields, decoded straight from the IR
  logic [2:0] w_class, w_func;
  logic       w_dest, w_src;
  logic [7:0] w_imm;
  assign w_class = r_ir[15:13];
  assign w_func  = r_ir[12:10];
  assign w_dest  = r_ir[9];
  assign w_src   = r_ir[8];
  assign w_imm   = r_ir[7:0];

  assign w_pc_inc = r_pc + ADDR_W'(1);

  // Jump targets come from the 8-bit immediate, fitted to the PC width
  if (ADDR_W > 8) begin : g_imm_zext
    assign w_imm_addr = {{(ADDR_W-8){1'b0}}, w_imm};
  end else if (ADDR_W == 8) begin : g_imm_exact
    assign w_imm_addr = w_imm;
  end else begin : g_imm_trunc
    assign w_imm_addr = w_imm[ADDR_W-1:0];
  end

  if (STACK_D < 1) begin : g_depth_check
    $error("STACK_D must be at least 1");
  end

`ifdef ACC_CALL_STACK_EN
  localparam int c_SP_W  = $clog2(STACK_D + 1);
  localparam int c_IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [ADDR_W-1:0]  r_stack [STACK_D];
  logic [c_SP_W-1:0]  r_sp, w_sp_dec;
  logic [c_IDX_W-1:0] w_push_idx, w_pop_idx;
  logic               w_push, w_pop, w_stack_full, w_stack_empty;

  assign w_sp_dec      = r_sp - 1'b1;
  assign w_push_idx    = r_sp[c_IDX_W-1:0];
  assign w_pop_idx     = w_sp_dec[c_IDX_W-1:0];
  assign w_stack_full  = (r_sp == c_SP_W'(STACK_D));
  assign w_stack_empty = (r_sp == '0);

  // Return-stack pointer; reset empties the stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_sp <= '0;
    else if (w_push) r_sp <= r_sp + 1'b1;
    else if (w_pop)  r_sp <= w_sp_dec;
  end

  // Return-address storage, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end
`endif

  // Branch condition evaluated on the selected registered flag bank
  always_comb begin
    logic z, c, n;
    z = w_dest ? bus.i_z_b : bus.i_z_a;
    c = w_dest ? bus.i_c_b : bus.i_c_a;
    n = w_dest ? bus.i_n_b : bus.i_n_a;
    case (w_func)
      3'd0:    w_taken = z;
      3'd1:    w_taken = c;
      3'd2:    w_taken = n;
      3'd3:    w_taken = !z;
      3'd4:    w_taken = !c;
      3'd5:    w_taken = !n;
      default: w_taken = 1'b0;
    endcase
  end

  // Sequencer state, PC, IR and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_acc_a <= '0;
      r_acc_b <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_acc_a <= w_acc_a_next;
      r_acc_b <= w_acc_b_next;
    end
  end

  // Next-state, register updates and ALU drive, decoded from state and IR
  always_comb begin
    w_next_state  = r_state;
    w_pc_next     = r_pc;
    w_ir_next     = r_ir;
    w_acc_a_next  = r_acc_a;
    w_acc_b_next  = r_acc_b;
    w_alu_control = c_ALU_IDLE;
    w_bank        = 1'b0;
    w_op_a        = 8'h00;
    w_op_b        = 8'h00;
`ifdef ACC_CALL_STACK_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        if (!bus.i_hold) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_ir_next    = bus.i_instruction;
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_next_state = S_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_class)
          c_CLS_ALU: begin
            w_alu_control = w_func;
            w_bank        = w_dest;
            w_op_a        = w_dest ? r_acc_b : r_acc_a;
            w_op_b        = w_src ? w_imm : (w_dest ? r_acc_a : r_acc_b);
            if (w_func != c_ALU_IDLE) begin
              if (w_dest) w_acc_b_next = bus.i_alu_result;
              else        w_acc_a_next = bus.i_alu_result;
            end
          end
          c_CLS_LOADI: begin
            if (w_dest) w_acc_b_next = w_imm;
            else        w_acc_a_next = w_imm;
          end
          c_CLS_JMP:    w_pc_next = w_imm_addr;
          c_CLS_BRANCH: if (w_taken) w_pc_next = w_imm_addr;
`ifdef ACC_CALL_STACK_EN
          c_CLS_CALL: begin
            if (w_stack_full) begin
              w_pc_next    = r_pc;
              w_next_state = S_HALT;
            end else begin
              w_push    = 1'b1;
              w_pc_next = w_imm_addr;
            end
          end
          c_CLS_RET: begin
            if (w_stack_empty) begin
              w_pc_next    = r_pc;
              w_next_state = S_HALT;
            end else begin
              w_pop     = 1'b1;
              w_pc_next = r_stack[w_pop_idx];
            end
          end
`endif
          c_CLS_HALT: begin
            w_pc_next    = r_pc;
            w_next_state = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: w_next_state = S_FETCH;
    endcase
  end

  assign bus.o_instr_addr     = r_pc;
  assign bus.o_alu_control    = w_alu_control;
  assign bus.o_reg_output_alu = w_bank;
  assign bus.o_operand_a      = w_op_a;
  assign bus.o_operand_b      = w_op_b;
  assign bus.o_acc_a          = r_acc_a;
  assign bus.o_acc_b          = r_acc_b;
  assign bus.o_halted         = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_acc_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_control_unit
//  Description : Self-checking bench for acc_control_unit with a
//                synchronous instruction ROM and a behavioural 8-bit ALU
//                with registered A/B flag banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  acc_control_unit_if #(.ADDR_W(8)) bus_if ();

  acc_control_unit #(.ADDR_W(8), .STACK_D(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Synchronous ROM: data appears the cycle after the address
  logic [15:0] rom [256];
  always @(posedge clk) bus_if.i_instruction <= rom[bus_if.o_instr_addr];

  // Behavioural ALU: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 idle
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = 9'd0;
    case (bus_if.o_alu_control)
      3'd0:    alu_wide = {1'b0, bus_if.o_operand_a} + {1'b0, bus_if.o_operand_b};
      3'd1:    alu_wide = {1'b0, bus_if.o_operand_a} - {1'b0, bus_if.o_operand_b};
      3'd2:    alu_wide = {1'b0, bus_if.o_operand_a & bus_if.o_operand_b};
      3'd3:    alu_wide = {1'b0, bus_if.o_operand_a | bus_if.o_operand_b};
      3'd4:    alu_wide = {1'b0, bus_if.o_operand_a ^ bus_if.o_operand_b};
      3'd5:    alu_wide = {bus_if.o_operand_a, 1'b0};
      3'd6:    alu_wide = {bus_if.o_operand_a[0], 1'b0, bus_if.o_operand_a[7:1]};
      default: alu_wide = {1'b0, bus_if.o_operand_a};
    endcase
  end
  assign bus_if.i_alu_result = alu_wide[7:0];

  logic n_a, z_a, c_a, n_b, z_b, c_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {n_a, z_a, c_a, n_b, z_b, c_b} <= 6'b0;
    end else if (bus_if.o_alu_control != 3'd7) begin
      if (bus_if.o_reg_output_alu) begin
        n_b <= alu_wide[7]; z_b <= (alu_wide[7:0] == 8'h00); c_b <= alu_wide[8];
      end else begin
        n_a <= alu_wide[7]; z_a <= (alu_wide[7:0] == 8'h00); c_a <= alu_wide[8];
      end
    end
  end
  assign bus_if.i_n_a = n_a;
  assign bus_if.i_z_a = z_a;
  assign bus_if.i_c_a = c_a;
  assign bus_if.i_n_b = n_b;
  assign bus_if.i_z_b = z_b;
  assign bus_if.i_c_b = c_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Hold reset, fill ROM with NOPs, then release on a falling edge
  task automatic start_reset();
    rst_n = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'hC000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  pre_a;
    logic [7:0]  pre_b;
    logic [15:0] ins0;
    logic [15:0] ins1;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [7:0]  exp_pc;
    logic        exp_halt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    int alu_busy;
    int add_cycle;

    // LOADI A,pre_a ; LOADI B,pre_b ; ins0 ; ins1 -> state after 12 cycles
    vecs[0]  = '{8'h05, 8'h03, 16'h0000, 16'hC000, 8'h08, 8'h03, 8'h04, 1'b0}; // ADD A
    vecs[1]  = '{8'h80, 8'h11, 16'h1400, 16'hC000, 8'h00, 8'h11, 8'h04, 1'b0}; // SHL A
    vecs[2]  = '{8'h08, 8'h00, 16'h0508, 16'h6020, 8'h00, 8'h00, 8'h20, 1'b0}; // SUB imm, BZ taken
    vecs[3]  = '{8'h09, 8'h00, 16'h0508, 16'h6020, 8'h01, 8'h00, 8'h04, 1'b0}; // BZ not taken
    vecs[4]  = '{8'h12, 8'h34, 16'h4030, 16'hC000, 8'h12, 8'h34, 8'h31, 1'b0}; // JMP
    vecs[5]  = '{8'h03, 8'h0A, 16'h0600, 16'hC000, 8'h03, 8'h07, 8'h04, 1'b0}; // SUB B<-B-A
    vecs[6]  = '{8'h05, 8'h06, 16'h1C00, 16'hC000, 8'h05, 8'h06, 8'h04, 1'b0}; // func 7
    vecs[7]  = '{8'h80, 8'h80, 16'h0200, 16'h6640, 8'h80, 8'h00, 8'h40, 1'b0}; // BC on B taken
    vecs[8]  = '{8'h01, 8'h01, 16'h0000, 16'h6C50, 8'h02, 8'h01, 8'h50, 1'b0}; // BNZ taken
    vecs[9]  = '{8'h01, 8'h01, 16'h0000, 16'h7850, 8'h02, 8'h01, 8'h04, 1'b0}; // cond 6 never
    vecs[10] = '{8'h01, 8'h02, 16'h22AA, 16'hC000, 8'h01, 8'hAA, 8'h04, 1'b0}; // LOADI B
`ifdef ACC_CALL_STACK_EN
    vecs[11] = '{8'h07, 8'h08, 16'h9040, 16'hC000, 8'h07, 8'h08, 8'h41, 1'b0}; // CALL
`else
    vecs[11] = '{8'h07, 8'h08, 16'h9040, 16'hC000, 8'h07, 8'h08, 8'h04, 1'b0}; // CALL as NOP
`endif
    vecs[12] = '{8'h0F, 8'hF0, 16'hE000, 16'hC000, 8'h0F, 8'hF0, 8'h02, 1'b1}; // HALT
    vecs[13] = '{8'h01, 8'h01, 16'h0200, 16'h6A60, 8'h01, 8'h02, 8'h04, 1'b0}; // BN on B not taken
    vecs[14] = '{8'h3C, 8'h00, 16'h090F, 16'hC000, 8'h0C, 8'h00, 8'h04, 1'b0}; // AND imm

    bus_if.i_hold = 1'b0;

    // Reset values while reset is asserted
    start_reset();
    run(2);
    check("rst_pc",  {24'd0, bus_if.o_instr_addr}, 32'h0);
    check("rst_acc", {16'd0, bus_if.o_acc_a, bus_if.o_acc_b}, 32'h0);
    check("rst_ctl", {29'd0, bus_if.o_alu_control}, 32'h7);
    check("rst_out", {15'd0, bus_if.o_reg_output_alu, bus_if.o_operand_a, bus_if.o_operand_b}, 32'h0);
    check("rst_halt", {31'd0, bus_if.o_halted}, 32'h0);

    // Table of short programs
    for (int i = 0; i < NV; i++) begin
      start_reset();
      rom[0] = 16'h2000 | {8'h00, vecs[i].pre_a};
      rom[1] = 16'h2200 | {8'h00, vecs[i].pre_b};
      rom[2] = vecs[i].ins0;
      rom[3] = vecs[i].ins1;
      release_reset();
      run(12);
      check($sformatf("v%0d_acc_a", i), {24'd0, bus_if.o_acc_a}, {24'd0, vecs[i].exp_a});
      check($sformatf("v%0d_acc_b", i), {24'd0, bus_if.o_acc_b}, {24'd0, vecs[i].exp_b});
      check($sformatf("v%0d_pc", i), {24'd0, bus_if.o_instr_addr}, {24'd0, vecs[i].exp_pc});
      check($sformatf("v%0d_halt", i), {31'd0, bus_if.o_halted}, {31'd0, vecs[i].exp_halt});
    end

    // ALU opcode is active only in the ADD execute cycle
    start_reset();
    rom[0] = 16'h2005; rom[1] = 16'h2203; rom[2] = 16'h0000;
    release_reset();
    alu_busy = 0; add_cycle = -1;
    for (int k = 1; k <= 9; k++) begin
      run(1);
      if (bus_if.o_alu_control != 3'd7) begin
        alu_busy++;
        if (bus_if.o_alu_control == 3'd0) add_cycle = k;
        check("add_opa", {24'd0, bus_if.o_operand_a}, 32'h05);
        check("add_opb", {24'd0, bus_if.o_operand_b}, 32'h03);
      end
    end
    check("alu_busy_cycles", alu_busy, 1);
    check("add_exec_cycle", add_cycle, 8);
    check("prog_acc_a", {24'd0, bus_if.o_acc_a}, 32'h08);
    check("prog_pc", {24'd0, bus_if.o_instr_addr}, 32'h03);

    // SHL sets A-bank Z and C; B-bank flags from the earlier ADD stay
    start_reset();
    rom[0] = 16'h2001; rom[1] = 16'h227F; rom[2] = 16'h0200;
    rom[3] = 16'h2080; rom[4] = 16'h1400;
    release_reset();
    run(15);
    check("shl_acc_a", {24'd0, bus_if.o_acc_a}, 32'h00);
    check("shl_flags_a", {29'd0, n_a, z_a, c_a}, 32'b011);
    check("shl_flags_b", {29'd0, n_b, z_b, c_b}, 32'b100);

    // PC wraps from 0xFF to 0x00
    start_reset();
    rom[0] = 16'h40FF;
    release_reset();
    run(6);
    check("pc_wrap", {24'd0, bus_if.o_instr_addr}, 32'h00);

    // HALT is terminal, hold has no effect there
    start_reset();
    rom[0] = 16'hE000;
    release_reset();
    run(3);
    check("halt_flag", {31'd0, bus_if.o_halted}, 32'h1);
    bus_if.i_hold = 1'b1;
    run(5);
    bus_if.i_hold = 1'b0;
    run(3);
    check("halt_pc", {24'd0, bus_if.o_instr_addr}, 32'h00);
    check("halt_stay", {31'd0, bus_if.o_halted}, 32'h1);

    // Hold freezes sequencing in FETCH
    start_reset();
    rom[0] = 16'h2055;
    bus_if.i_hold = 1'b1;
    release_reset();
    run(5);
    check("hold_pc", {24'd0, bus_if.o_instr_addr}, 32'h00);
    check("hold_acc", {24'd0, bus_if.o_acc_a}, 32'h00);
    bus_if.i_hold = 1'b0;
    run(3);
    check("hold_release_pc", {24'd0, bus_if.o_instr_addr}, 32'h01);
    check("hold_release_acc", {24'd0, bus_if.o_acc_a}, 32'h55);

    // Reset in the middle of the ADD execute cycle
    start_reset();
    rom[0] = 16'h2005; rom[1] = 16'h2203; rom[2] = 16'h0000;
    release_reset();
    run(8);
    check("mid_ctl_before", {29'd0, bus_if.o_alu_control}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_acc", {16'd0, bus_if.o_acc_a, bus_if.o_acc_b}, 32'h0);
    check("mid_pc", {24'd0, bus_if.o_instr_addr}, 32'h0);
    check("mid_ctl", {29'd0, bus_if.o_alu_control}, 32'h7);
    @(posedge clk); #1;
    check("mid_acc_after_edge", {24'd0, bus_if.o_acc_a}, 32'h0);

`ifdef ACC_CALL_STACK_EN
    // CALL from 0x10 then RET returns to 0x11
    start_reset();
    rom[8'h00] = 16'h4010; rom[8'h10] = 16'h9040; rom[8'h40] = 16'hA000;
    release_reset();
    run(9);
    check("call_ret_pc", {24'd0, bus_if.o_instr_addr}, 32'h11);

    // Fifth nested CALL overflows the four-entry stack
    start_reset();
    rom[8'h00] = 16'h9010; rom[8'h10] = 16'h9020; rom[8'h20] = 16'h9030;
    rom[8'h30] = 16'h9040; rom[8'h40] = 16'h9050;
    release_reset();
    run(15);
    check("call_ovf_halt", {31'd0, bus_if.o_halted}, 32'h1);
    check("call_ovf_pc", {24'd0, bus_if.o_instr_addr}, 32'h40);

    // RET on an empty stack halts
    start_reset();
    rom[0] = 16'hA000;
    release_reset();
    run(3);
    check("ret_empty_halt", {31'd0, bus_if.o_halted}, 32'h1);
    check("ret_empty_pc", {24'd0, bus_if.o_instr_addr}, 32'h00);
`else
    // Without the stack, RET is a NOP as well
    start_reset();
    rom[0] = 16'hA000;
    release_reset();
    run(3);
    check("ret_nop_pc", {24'd0, bus_if.o_instr_addr}, 32'h01);
    check("ret_nop_halt", {31'd0, bus_if.o_halted}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer sitting directly upstream of the 8-bit ALU.
- Owns the program counter and the two accumulators, AccA and AccB.
- Drives the ALU's operation code, operands and flag-bank select.
- Captures the ALU result into the destination accumulator and consumes the registered flags for conditional branches.

Parameters:
ADDR_W, 8, program counter / instruction ROM address width
STACK_D, 4, return-stack depth (used only with the optional feature)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
iHold  in  1  1 = remain in FETCH (freeze sequencing)
oInstrAddr  out  ADDR_W  synchronous ROM address (= PC)
iInstruction  in  16  ROM data, valid the cycle after oInstrAddr is presented
oALUControl  out  3  ALU operation code; 7 = idle, flags hold
oRegOutputALU  out  1  flag bank written: 0 = A bank, 1 = B bank
oOperandA  out  8  ALU A operand (destination accumulator)
oOperandB  out  8  ALU B operand (other accumulator or immediate)
iALUResult  in  8  ALU result, combinational from operands/control
iN_A, iZ_A, iC_A, iN_B, iZ_B, iC_B  in  1 each  registered ALU flags
oAccA, oAccB  out  8  accumulator contents
oHalted  out  1  1 while in HALT

Behaviour:
- Reset (Reset=0, async):
  - State FETCH; PC=0; AccA=AccB=0; IR=0.
  - oALUControl=7; oRegOutputALU=0; oOperandA/B=0; oHalted=0.
- FSM states: FETCH, DECODE, EXECUTE, HALT. Three cycles per instruction.
  - FETCH: oInstrAddr=PC. If iHold=1, stay in FETCH; otherwise go to DECODE.
  - DECODE: IR<=iInstruction; go to EXECUTE.
  - EXECUTE: act on IR (below); go to FETCH, or to HALT.
  - HALT: terminal; only Reset exits.
- Instruction format: [15:13] class, [12:10] func/cond, [9] dest/bank, [8] src, [7:0] imm.
- Class 000, ALU:
  - In EXECUTE: oALUControl=func; oRegOutputALU=[9]; oOperandA=dest accumulator (A if [9]=0, else B).
  - oOperandB = other accumulator if [8]=0, else imm.
  - At the edge ending EXECUTE, dest <= iALUResult. The ALU latches its flags on the same edge.
  - func=7: no accumulator write; flags untouched.
- Class 001, LOADI: dest[9] <= imm; oALUControl stays 7.
- Class 010, JMP: PC <= imm[ADDR_W-1:0], zero-extended if ADDR_W>8.
- Class 011, BRANCH:
  - Bank [9] selects the A or B flag set.
  - cond: 0=Z, 1=C, 2=N, 3=!Z, 4=!C, 5=!N; 6 and 7 are never taken.
  - Taken: PC <= imm. Not taken: PC+1.
  - Flags sampled are those registered by earlier instructions.
- Class 111, HALT: PC unchanged; next state HALT.
- Classes 100/101: see Optional Feature. Class 110: NOP.
- PC update in EXECUTE for all non-jump cases: PC+1, wrapping from 2^ADDR_W-1 to 0.
- oALUControl=7 in every state/class except ALU-class EXECUTE. Flags therefore never change outside ALU instructions.
- Accumulators change only at the edge ending EXECUTE; outputs are registered or decoded from the state/IR registers.
- Reset asserted mid-instruction: immediate return to reset values. No partial write survives.
- iHold is sampled only in FETCH.

Optional Feature:
- Macro ACC_CALL_STACK_EN.
- Defined:
  - Class 100 CALL: push PC+1 (wrapped), then PC <= imm.
  - Class 101 RET: pop into PC.
  - Stack is STACK_D entries deep.
  - CALL on a full stack or RET on an empty stack: no push/pop, PC unchanged, enter HALT.
  - Reset empties the stack.
- Undefined: classes 100/101 behave as NOP (PC+1); no stack storage is synthesized.

Test Plan:
- Reset then LOADI A,0x05 (0x2005); LOADI B,0x03 (0x2203); ADD A<-A+B (0x0000) -> AccA=0x08, AccB=0x03, PC=3 after 9 cycles; oALUControl=0 only during the ADD EXECUTE.
- AccA=0x80, SHL A (0x1400) -> AccA=0x00; A-bank flags Z=1, C=1; B-bank flags unchanged.
- SUB A<-A-imm 0x08 with AccA=0x08 (0x0508) then BRANCH Z,A to 0x20 (0x6020) -> PC=0x20. Repeat with AccA=0x09 -> PC=next sequential.
- PC=0xFF (ADDR_W=8), NOP -> PC wraps to 0x00. HALT (0xE000) -> oHalted=1 and PC frozen; iHold=1 during FETCH for 5 cycles -> no PC or state change.
- Assert Reset low during EXECUTE of ADD -> AccA=0, PC=0, state FETCH, oALUControl=7 asynchronously.
- With ACC_CALL_STACK_EN: CALL 0x40 from PC=0x10, RET -> PC=0x11. Five nested CALLs -> HALT on the 5th. Without the macro: CALL -> PC+1.
